// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master line-burst memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BURST = 2'd1,
        D_BURST = 2'd2
    } arb_state_t;

    typedef enum logic {
        MASTER_I = 1'b0,
        MASTER_D = 1'b1
    } master_t;

    localparam int unsigned WORD_OFFSET = 2;

    // Number of address bits covered by one line (beat index + byte-in-word).
    function automatic int unsigned line_offset_bits(input int unsigned burst_len);
        return $clog2(burst_len) + WORD_OFFSET;
    endfunction

endpackage

// File: rtl/mem_beat_ctr.sv
// Modulo-BURST_LEN beat counter with synchronous clear, enable and last-beat flag.
module mem_beat_ctr #(
    parameter  int unsigned BURST_LEN = 4,
    localparam int unsigned BEAT_W    = $clog2(BURST_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [BEAT_W-1:0] beat,
    output logic              last_beat
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            beat <= '0;
        end else if (en) begin
            beat <= beat + BEAT_W'(1);
        end
    end

    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between I-side refills and D-side
// refills/writebacks; each grant runs one line-aligned burst of BURST_LEN beats.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned BURST_LEN = 4,
    localparam int unsigned BEAT_W    = $clog2(BURST_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [BEAT_W-1:0] d_beat,
    output logic              d_wready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned       OFF_W     = line_offset_bits(BURST_LEN);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    arb_state_t        state;
    master_t           last;
    logic [ADDR_W-1:0] base;
    logic              we_q;
    logic [BEAT_W-1:0] beat;
    logic              last_beat;
    logic              in_i;
    logic              in_d;
    logic              beat_ack;
    logic              grant_i;
    logic              grant_d;

    assign in_i     = (state == I_BURST);
    assign in_d     = (state == D_BURST);
    assign beat_ack = (in_i || in_d) && mem_ack;

    // On a tie the master that was not granted last time wins.
    assign grant_d = (state == IDLE) && d_req && (!i_req || (last == MASTER_I));
    assign grant_i = (state == IDLE) && i_req && !grant_d;

    mem_beat_ctr #(
        .BURST_LEN(BURST_LEN)
    ) u_beat_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant_i || grant_d),
        .en       (beat_ack),
        .beat     (beat),
        .last_beat(last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= MASTER_I;
            base  <= '0;
            we_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state <= D_BURST;
                        base  <= d_addr & LINE_MASK;
                        we_q  <= d_we;
                        last  <= MASTER_D;
                    end else if (grant_i) begin
                        state <= I_BURST;
                        base  <= i_addr & LINE_MASK;
                        we_q  <= 1'b0;
                        last  <= MASTER_I;
                    end
                end
                I_BURST, D_BURST: begin
                    if (beat_ack && last_beat) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_req   = in_i || in_d;
        mem_we    = in_d && we_q;
        mem_addr  = mem_req ? (base + (ADDR_W'(beat) << WORD_OFFSET)) : '0;
        mem_wdata = d_wdata;
        i_rvalid  = in_i && mem_ack;
        d_rvalid  = in_d && !we_q && mem_ack;
        d_wready  = in_d && we_q && mem_ack;
        i_done    = in_i && mem_ack && last_beat;
        d_done    = in_d && mem_ack && last_beat;
        d_beat    = beat;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
    end

endmodule
